dds_sweep_ctrl: RTL and testbench
=================================

Name: dds_sweep_ctrl

Overview:
- Sequencer that owns the DDS_Top register-write bus (wr/waddr/wdata).
- Runs programmable linear frequency sweeps: enables the DDS, then steps the frequency register at a fixed dwell interval.
- Arbitrates a host register-write port onto the same bus, so software can still reach any DDS register.
- Sits between the host/config logic and DDS_Top.

Parameters:
- AW, 16, register address width
- DW, 16, register data width
- FREQ_ADDR, 16'h0020, DDS frequency-word register address
- CTRL_ADDR, 16'h0030, DDS control register address
- CTRL_EN_VAL, 16'h000F, control value written at sweep start
- CTRL_DIS_VAL, 16'h0000, control value written on abort
- DWELL_W, 16, dwell counter width

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle sweep start request
- abort  in  1  one-cycle sweep abort request
- cfg_f0  in  DW  start frequency word
- cfg_step  in  DW  frequency increment per step
- cfg_nsteps  in  16  number of increments; total frequency writes = cfg_nsteps+1
- cfg_dwell  in  DWELL_W  idle cycles between frequency writes; 0 is treated as 1
- cfg_loop  in  1  0 = single sweep, 1 = repeat from cfg_f0 until abort
- host_wr  in  1  host write request, held high until acknowledged
- host_waddr  in  AW  host write address
- host_wdata  in  DW  host write data
- host_ack  out  1  combinational grant; the host drops host_wr after the cycle host_ack is high
- wr  out  1  DDS write strobe (registered)
- waddr  out  AW  DDS write address (registered)
- wdata  out  DW  DDS write data (registered)
- busy  out  1  high whenever the FSM is not IDLE
- done  out  1  one-cycle pulse at normal sweep completion
- cur_freq  out  DW  last frequency word written by the sweep engine

Behaviour:
- Reset: FSM=IDLE. wr, waddr, wdata, host_ack, busy, done and cur_freq are all 0. Counters and latched cfg are cleared.
- Bus rules:
  - wr is a single-cycle pulse.
  - waddr and wdata are valid only while wr=1 and are driven to 0 otherwise.
  - At most one write per cycle.
  - A write granted in cycle n appears on the bus in cycle n+1.
- Arbitration:
  - The host has priority. host_ack = host_wr in any cycle.
  - The sweep engine may issue only in states CTRL_WR, FREQ_WR and STOP_WR, and only when host_wr=0; otherwise it stalls in that state.
  - Dwell counting starts only after the sweep's frequency write is granted.
- States:
  - IDLE: on start (and not abort), latch all cfg_* inputs, set step_cnt=0, go to CTRL_WR. start while busy is ignored. abort in IDLE is a no-op and wins over a simultaneous start.
  - CTRL_WR: on grant, write CTRL_ADDR/CTRL_EN_VAL, then go to FREQ_WR with freq=f0.
  - FREQ_WR: on grant, write FREQ_ADDR/freq and set cur_freq<=freq, then go to DWELL with dwell_cnt=max(cfg_dwell,1).
  - DWELL: decrement dwell_cnt; when it reaches 0:
    - if step_cnt<nsteps: freq<=freq+step (modulo 2^DW, wraps silently), step_cnt++, go to FREQ_WR;
    - else if loop: freq<=f0, step_cnt<=0, go to FREQ_WR (no control rewrite);
    - else: pulse done, go to IDLE.
  - STOP_WR: entered from any non-IDLE state on abort. On grant, write CTRL_ADDR/CTRL_DIS_VAL, then go to IDLE. No done pulse.
- Abort details:
  - A write already registered on the bus still completes.
  - A sweep write granted in the same cycle as abort is still issued.
  - abort while in STOP_WR is ignored.
- Timing:
  - Uncontended spacing between successive frequency writes is dwell+1 cycles.
  - With start sampled at cycle k: control write appears in cycle k+2, first frequency write in k+3.
- Asynchronous reset mid-sweep: immediate return to the reset state. No stop write is issued.

Decomposition:
- Shared package dds_pkg:
  - FSM state enum (IDLE, CTRL_WR, FREQ_WR, DWELL, STOP_WR)
  - register-map constants FREQ_ADDR and CTRL_ADDR
  - CTRL_EN_VAL and CTRL_DIS_VAL
- One natural sub-module, dds_wr_arb: host/sweep priority mux plus registered bus outputs. It is reusable by other DDS register masters.

Test Plan:
- Basic sweep: f0=0x0100, step=0x0010, nsteps=3, dwell=4, loop=0 -> writes (0x30,0x000F), then (0x20,0x0100/0x0110/0x0120/0x0130) spaced 5 cycles apart; done pulses once; busy drops.
- Host contention: hold host_wr at (0x40,0x1234) over the cycle of the second frequency write -> host write issued first with host_ack, sweep write delayed exactly 1 cycle, later spacing unchanged.
- Abort mid-dwell: after the 2nd frequency write, pulse abort -> next write is (0x30,0x0000), then IDLE; no done pulse; cur_freq=0x0110.
- Wrap and loop: f0=0xFFF0, step=0x0020, nsteps=1, loop=1 -> writes 0xFFF0, 0x0010, 0xFFF0, ...; no control rewrite; done never pulses.
- Edge configs:
  - dwell=0 behaves as dwell=1;
  - nsteps=0 gives exactly one frequency write then done;
  - start+abort together in IDLE gives no bus activity;
  - start while busy is ignored.
- Reset mid-sweep: deassert rstn during DWELL -> all outputs 0 immediately; after release, no writes until a new start.

Source files
------------

// File: rtl/dds_pkg.sv
`timescale 1ns/1ps
// Shared definitions for DDS register masters: sweep FSM states and register map.
package dds_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CTRL_WR = 3'd1,
    ST_FREQ_WR = 3'd2,
    ST_DWELL   = 3'd3,
    ST_STOP_WR = 3'd4
  } state_e;

  localparam logic [15:0] FREQ_ADDR    = 16'h0020;
  localparam logic [15:0] CTRL_ADDR    = 16'h0030;
  localparam logic [15:0] CTRL_EN_VAL  = 16'h000F;
  localparam logic [15:0] CTRL_DIS_VAL = 16'h0000;

endpackage

// File: rtl/dds_wr_arb.sv
`timescale 1ns/1ps
// Two-master write arbiter for the DDS register bus: host always wins, and the
// winning request is registered onto wr/waddr/wdata one cycle after the grant.
module dds_wr_arb #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_host_wr,
  input  logic [AW-1:0] i_host_waddr,
  input  logic [DW-1:0] i_host_wdata,
  output logic          o_host_ack,
  input  logic          i_eng_req,
  input  logic [AW-1:0] i_eng_waddr,
  input  logic [DW-1:0] i_eng_wdata,
  output logic          o_eng_gnt,
  output logic          o_wr,
  output logic [AW-1:0] o_waddr,
  output logic [DW-1:0] o_wdata
);

  logic          r_wr;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;

  assign o_host_ack = i_host_wr;
  assign o_eng_gnt  = i_eng_req & ~i_host_wr;

  // Address and data return to zero whenever no write is on the bus.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (i_host_wr) begin
      r_wr    <= 1'b1;
      r_waddr <= i_host_waddr;
      r_wdata <= i_host_wdata;
    end else if (i_eng_req) begin
      r_wr    <= 1'b1;
      r_waddr <= i_eng_waddr;
      r_wdata <= i_eng_wdata;
    end else begin
      r_wr    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end
  end

  assign o_wr    = r_wr;
  assign o_waddr = r_waddr;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/dds_sweep_ctrl.sv
`timescale 1ns/1ps
// Linear frequency-sweep sequencer for DDS_Top; shares the register-write bus
// with a host port through dds_wr_arb.
module dds_sweep_ctrl #(
  parameter int              AW           = 16,
  parameter int              DW           = 16,
  parameter logic [AW-1:0]   FREQ_ADDR    = AW'(dds_pkg::FREQ_ADDR),
  parameter logic [AW-1:0]   CTRL_ADDR    = AW'(dds_pkg::CTRL_ADDR),
  parameter logic [DW-1:0]   CTRL_EN_VAL  = DW'(dds_pkg::CTRL_EN_VAL),
  parameter logic [DW-1:0]   CTRL_DIS_VAL = DW'(dds_pkg::CTRL_DIS_VAL),
  parameter int              DWELL_W      = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               abort,
  input  logic [DW-1:0]      cfg_f0,
  input  logic [DW-1:0]      cfg_step,
  input  logic [15:0]        cfg_nsteps,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  input  logic               host_wr,
  input  logic [AW-1:0]      host_waddr,
  input  logic [DW-1:0]      host_wdata,
  output logic               host_ack,
  output logic               wr,
  output logic [AW-1:0]      waddr,
  output logic [DW-1:0]      wdata,
  output logic               busy,
  output logic               done,
  output logic [DW-1:0]      cur_freq
);
  import dds_pkg::*;

  state_e             r_state;
  logic [DW-1:0]      r_f0;
  logic [DW-1:0]      r_step;
  logic [15:0]        r_nsteps;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_loop;
  logic [DW-1:0]      r_freq;
  logic [15:0]        r_step_cnt;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic [DW-1:0]      r_cur_freq;
  logic               r_done;

  logic               w_eng_req;
  logic [AW-1:0]      w_eng_waddr;
  logic [DW-1:0]      w_eng_wdata;
  logic               w_eng_gnt;
  logic [DWELL_W-1:0] w_dwell_load;

  assign w_dwell_load = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;

  always_comb begin
    w_eng_req   = 1'b0;
    w_eng_waddr = '0;
    w_eng_wdata = '0;
    case (r_state)
      ST_CTRL_WR: begin
        w_eng_req   = 1'b1;
        w_eng_waddr = CTRL_ADDR;
        w_eng_wdata = CTRL_EN_VAL;
      end
      ST_FREQ_WR: begin
        w_eng_req   = 1'b1;
        w_eng_waddr = FREQ_ADDR;
        w_eng_wdata = r_freq;
      end
      ST_STOP_WR: begin
        w_eng_req   = 1'b1;
        w_eng_waddr = CTRL_ADDR;
        w_eng_wdata = CTRL_DIS_VAL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_f0        <= '0;
      r_step      <= '0;
      r_nsteps    <= '0;
      r_dwell     <= '0;
      r_loop      <= 1'b0;
      r_freq      <= '0;
      r_step_cnt  <= '0;
      r_dwell_cnt <= '0;
      r_cur_freq  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_f0       <= cfg_f0;
            r_step     <= cfg_step;
            r_nsteps   <= cfg_nsteps;
            r_dwell    <= w_dwell_load;
            r_loop     <= cfg_loop;
            r_step_cnt <= '0;
            r_state    <= ST_CTRL_WR;
          end
        end
        ST_CTRL_WR: begin
          if (abort) begin
            r_state <= ST_STOP_WR;
          end else if (w_eng_gnt) begin
            r_freq  <= r_f0;
            r_state <= ST_FREQ_WR;
          end
        end
        ST_FREQ_WR: begin
          // A write granted alongside abort still goes out, so track it.
          if (w_eng_gnt) begin
            r_cur_freq  <= r_freq;
            r_dwell_cnt <= r_dwell;
          end
          if (abort) begin
            r_state <= ST_STOP_WR;
          end else if (w_eng_gnt) begin
            r_state <= ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (abort) begin
            r_state <= ST_STOP_WR;
          end else if (r_dwell_cnt > DWELL_W'(1)) begin
            r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
          end else if (r_step_cnt < r_nsteps) begin
            r_freq     <= r_freq + r_step;
            r_step_cnt <= r_step_cnt + 16'd1;
            r_state    <= ST_FREQ_WR;
          end else if (r_loop) begin
            r_freq     <= r_f0;
            r_step_cnt <= '0;
            r_state    <= ST_FREQ_WR;
          end else begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_STOP_WR: begin
          if (w_eng_gnt) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  dds_wr_arb #(
    .AW (AW),
    .DW (DW)
  ) u_arb (
    .clk          (clk),
    .rstn         (rstn),
    .i_host_wr    (host_wr),
    .i_host_waddr (host_waddr),
    .i_host_wdata (host_wdata),
    .o_host_ack   (host_ack),
    .i_eng_req    (w_eng_req),
    .i_eng_waddr  (w_eng_waddr),
    .i_eng_wdata  (w_eng_wdata),
    .o_eng_gnt    (w_eng_gnt),
    .o_wr         (wr),
    .o_waddr      (waddr),
    .o_wdata      (wdata)
  );

  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign cur_freq = r_cur_freq;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
`timescale 1ns/1ps
// Directed bench for dds_sweep_ctrl: logs every bus write with its cycle number
// and checks contents and spacing against hand-computed schedules.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_f0 = '0;
  logic [15:0] cfg_step = '0;
  logic [15:0] cfg_nsteps = '0;
  logic [15:0] cfg_dwell = '0;
  logic        cfg_loop = 1'b0;
  logic        host_wr = 1'b0;
  logic [15:0] host_waddr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_ack;
  logic        wr;
  logic [15:0] waddr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic [15:0] cur_freq;

  dds_sweep_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .abort      (abort),
    .cfg_f0     (cfg_f0),
    .cfg_step   (cfg_step),
    .cfg_nsteps (cfg_nsteps),
    .cfg_dwell  (cfg_dwell),
    .cfg_loop   (cfg_loop),
    .host_wr    (host_wr),
    .host_waddr (host_waddr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .wr         (wr),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .cur_freq   (cur_freq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] log_addr [256];
  logic [15:0] log_data [256];
  int          log_cyc  [256];
  int          log_n = 0;
  int          done_cnt = 0;
  int          last_done = 0;

  always @(negedge clk) begin
    if (wr && log_n < 256) begin
      log_addr[log_n] <= waddr;
      log_data[log_n] <= wdata;
      log_cyc[log_n]  <= cyc;
      log_n           <= log_n + 1;
    end
    if (done) begin
      done_cnt  <= done_cnt + 1;
      last_done <= cyc;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {addr, data, cycle offset from start} so one compare covers a write.
  task automatic chk_wr(input string tag, input int idx, input logic [15:0] a,
                        input logic [15:0] d, input int rel, input int s);
    chk(tag, {log_addr[idx], log_data[idx], 32'(log_cyc[idx] - s)}, {a, d, 32'(rel)});
  endtask

  task automatic set_cfg(input logic [15:0] f0, input logic [15:0] st, input logic [15:0] ns,
                         input logic [15:0] dw, input logic lp);
    cfg_f0     = f0;
    cfg_step   = st;
    cfg_nsteps = ns;
    cfg_dwell  = dw;
    cfg_loop   = lp;
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, output int ic);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    ic = cyc;
    chk(tag, 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int s, b, d0, ic;

    repeat (3) @(negedge clk);
    chk("rst_outputs", {wr, waddr, wdata, busy, done, cur_freq, host_ack}, 64'(0));
    rstn = 1'b1;
    @(negedge clk);

    // Basic sweep
    set_cfg(16'h0100, 16'h0010, 16'd3, 16'd4, 1'b0);
    b = log_n; d0 = done_cnt;
    pulse_start(s);
    chk("t1_busy", 64'(busy), 64'(1));
    wait_idle("t1_idle", ic);
    chk("t1_idle_cyc", 64'(ic - s), 64'(22));
    chk("t1_nwr", 64'(log_n - b), 64'(5));
    chk_wr("t1_ctrl", b, 16'h0030, 16'h000F, 2, s);
    for (int i = 0; i < 4; i++)
      chk_wr("t1_freq", b + 1 + i, 16'h0020, 16'h0100 + 16'(i * 16), 3 + 5 * i, s);
    chk("t1_done", 64'(done_cnt - d0), 64'(1));
    chk("t1_done_cyc", 64'(last_done - s), 64'(22));
    chk("t1_cur", 64'(cur_freq), 64'h0130);

    // Host contention on the second frequency write
    b = log_n; d0 = done_cnt;
    pulse_start(s);
    wait_cyc(s + 7);
    host_waddr = 16'h0040; host_wdata = 16'h1234; host_wr = 1'b1;
    #1 chk("t2_ack", 64'(host_ack), 64'(1));
    @(negedge clk);
    host_wr = 1'b0;
    #1 chk("t2_ack_lo", 64'(host_ack), 64'(0));
    wait_idle("t2_idle", ic);
    chk("t2_nwr", 64'(log_n - b), 64'(6));
    chk_wr("t2_ctrl", b, 16'h0030, 16'h000F, 2, s);
    chk_wr("t2_f0", b + 1, 16'h0020, 16'h0100, 3, s);
    chk_wr("t2_host", b + 2, 16'h0040, 16'h1234, 8, s);
    chk_wr("t2_f1", b + 3, 16'h0020, 16'h0110, 9, s);
    chk_wr("t2_f2", b + 4, 16'h0020, 16'h0120, 14, s);
    chk_wr("t2_f3", b + 5, 16'h0020, 16'h0130, 19, s);
    chk("t2_done_cyc", 64'(last_done - s), 64'(23));

    // Abort mid-dwell
    b = log_n; d0 = done_cnt;
    pulse_start(s);
    wait_cyc(s + 9);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle("t3_idle", ic);
    chk("t3_idle_cyc", 64'(ic - s), 64'(11));
    chk("t3_nwr", 64'(log_n - b), 64'(4));
    chk_wr("t3_f1", b + 2, 16'h0020, 16'h0110, 8, s);
    chk_wr("t3_stop", b + 3, 16'h0030, 16'h0000, 11, s);
    chk("t3_nodone", 64'(done_cnt - d0), 64'(0));
    chk("t3_cur", 64'(cur_freq), 64'h0110);

    // Wrap and loop, stopped by abort
    set_cfg(16'hFFF0, 16'h0020, 16'd1, 16'd2, 1'b1);
    b = log_n; d0 = done_cnt;
    pulse_start(s);
    wait_cyc(s + 16);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle("t4_idle", ic);
    chk("t4_nwr", 64'(log_n - b), 64'(7));
    chk_wr("t4_ctrl", b, 16'h0030, 16'h000F, 2, s);
    chk_wr("t4_f0", b + 1, 16'h0020, 16'hFFF0, 3, s);
    chk_wr("t4_f1", b + 2, 16'h0020, 16'h0010, 6, s);
    chk_wr("t4_f2", b + 3, 16'h0020, 16'hFFF0, 9, s);
    chk_wr("t4_f3", b + 4, 16'h0020, 16'h0010, 12, s);
    chk_wr("t4_f4", b + 5, 16'h0020, 16'hFFF0, 15, s);
    chk_wr("t4_stop", b + 6, 16'h0030, 16'h0000, 18, s);
    chk("t4_nodone", 64'(done_cnt - d0), 64'(0));

    // dwell=0 acts as dwell=1
    set_cfg(16'h0005, 16'h0003, 16'd2, 16'd0, 1'b0);
    b = log_n; d0 = done_cnt;
    pulse_start(s);
    wait_idle("t5a_idle", ic);
    chk("t5a_nwr", 64'(log_n - b), 64'(4));
    chk_wr("t5a_f0", b + 1, 16'h0020, 16'h0005, 3, s);
    chk_wr("t5a_f1", b + 2, 16'h0020, 16'h0008, 5, s);
    chk_wr("t5a_f2", b + 3, 16'h0020, 16'h000B, 7, s);
    chk("t5a_done_cyc", 64'(last_done - s), 64'(8));

    // nsteps=0: one frequency write then done
    set_cfg(16'h0AAA, 16'h0001, 16'd0, 16'd3, 1'b0);
    b = log_n; d0 = done_cnt;
    pulse_start(s);
    wait_idle("t5b_idle", ic);
    chk("t5b_nwr", 64'(log_n - b), 64'(2));
    chk_wr("t5b_f0", b + 1, 16'h0020, 16'h0AAA, 3, s);
    chk("t5b_done", 64'(done_cnt - d0), 64'(1));
    chk("t5b_idle_cyc", 64'(ic - s), 64'(6));

    // start+abort together in IDLE
    b = log_n;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("t6_busy", 64'(busy), 64'(0));
    repeat (5) @(negedge clk);
    chk("t6_nwr", 64'(log_n - b), 64'(0));

    // start while busy is ignored; cfg changes mid-sweep have no effect
    set_cfg(16'h0100, 16'h0010, 16'd1, 16'd2, 1'b0);
    b = log_n; d0 = done_cnt;
    pulse_start(s);
    set_cfg(16'h7777, 16'h0001, 16'd5, 16'd9, 1'b1);
    wait_cyc(s + 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("t7_idle", ic);
    chk("t7_nwr", 64'(log_n - b), 64'(3));
    chk_wr("t7_f0", b + 1, 16'h0020, 16'h0100, 3, s);
    chk_wr("t7_f1", b + 2, 16'h0020, 16'h0110, 6, s);
    chk("t7_done_cyc", 64'(last_done - s), 64'(8));

    // Reset during DWELL
    set_cfg(16'h0100, 16'h0010, 16'd3, 16'd4, 1'b0);
    b = log_n;
    pulse_start(s);
    wait_cyc(s + 5);
    rstn = 1'b0;
    #1 chk("t8_rst", {wr, waddr, wdata, busy, done, cur_freq}, 64'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (12) @(negedge clk);
    chk("t8_nwr", 64'(log_n - b), 64'(2));
    chk("t8_busy", 64'(busy), 64'(0));
    set_cfg(16'h0042, 16'h0000, 16'd0, 16'd1, 1'b0);
    pulse_start(s);
    wait_idle("t8_idle", ic);
    chk("t8_cur", 64'(cur_freq), 64'h0042);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
